// File: rtl/sym_matrix_pkg.sv
// Shared opcodes, FSM states and the triangular position helper for the
// symmetric relation store.
package sym_matrix_pkg;

  typedef enum logic [1:0] {
    OP_READ     = 2'b00,
    OP_WRITE    = 2'b01,
    OP_ROW_READ = 2'b10,
    OP_CLEAR    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  // Linear index of (hi, lo) with hi > lo in the packed lower triangle.
  function automatic int unsigned tri_pos(input int unsigned hi, input int unsigned lo);
    return (hi * (hi - 1)) / 2 + lo;
  endfunction

endpackage

// File: rtl/sym_matrix_if.sv
// Request/response bundle between a requester (master) and the relation
// store (slave).
interface sym_matrix_if #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
);
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [IW-1:0] row;
  logic [IW-1:0] col;
  logic          bit_in;
  logic          rsp_valid;
  logic          rsp_bit;
  logic [N-1:0]  row_vec;

  modport master (
    output req_valid, req_op, row, col, bit_in,
    input  req_ready, rsp_valid, rsp_bit, row_vec
  );

  modport slave (
    input  req_valid, req_op, row, col, bit_in,
    output req_ready, rsp_valid, rsp_bit, row_vec
  );
endinterface

// File: rtl/sym_matrix_addr.sv
// Combinational (row, col) -> triangular position decode with diagonal and
// out-of-range flags.
module sym_matrix_addr
  import sym_matrix_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = $clog2(N),
  parameter int PW = 5
) (
  input  logic [IW-1:0] row,
  input  logic [IW-1:0] col,
  output logic [PW-1:0] pos,
  output logic          is_diag,
  output logic          out_of_range
);
  logic [IW-1:0] hi;
  logic [IW-1:0] lo;

  always_comb begin
    hi = col;
    lo = row;
    if (row > col) begin
      hi = row;
      lo = col;
    end
  end

  assign pos     = PW'(tri_pos(32'(hi), 32'(lo)));
  assign is_diag = (row == col);

  // Indices can only exceed N-1 when N is not a power of two.
  generate
    if ((1 << IW) > N) begin : g_oor
      assign out_of_range = (32'(row) >= N) || (32'(col) >= N);
    end else begin : g_in_range
      assign out_of_range = 1'b0;
    end
  endgenerate
endmodule

// File: rtl/sym_matrix_ctl.sv
// Symmetric relation bit store with single-bit access, row scan and clear
// sweep. Optional SYM_MATRIX_POPCOUNT_EN adds a live count of set bits.
module sym_matrix_ctl
  import sym_matrix_pkg::*;
#(
  parameter int   N    = 8,
  parameter int   IW   = $clog2(N),
  parameter int   L    = N * (N - 1) / 2,
  parameter int   PW   = (L > 1) ? $clog2(L) : 1,
  parameter logic DIAG = 1'b1
) (
  input  logic           clock,
  input  logic           reset_n,
  sym_matrix_if.slave    bus,
  output logic           busy
`ifdef SYM_MATRIX_POPCOUNT_EN
  ,
  output logic [$clog2(L+1)-1:0] pop_count
`endif
);
  state_e        state_q, state_d;
  logic [L-1:0]  mem_q, mem_d;
  logic [IW-1:0] k_q, k_d;
  logic [IW-1:0] scan_row_q, scan_row_d;
  logic [N-1:0]  scan_vec_q, scan_vec_d;
  logic [PW-1:0] clr_q, clr_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_bit_q, rsp_bit_d;
  logic [N-1:0]  row_vec_q, row_vec_d;
`ifdef SYM_MATRIX_POPCOUNT_EN
  logic [$clog2(L+1)-1:0] pop_q, pop_d;
`endif

  logic [PW-1:0] req_pos, scan_pos;
  logic          req_diag, req_oor, scan_diag, scan_oor;
  logic          accept, scan_bit;

  sym_matrix_addr #(.N(N), .IW(IW), .PW(PW)) u_req_addr (
    .row(bus.row), .col(bus.col),
    .pos(req_pos), .is_diag(req_diag), .out_of_range(req_oor)
  );

  sym_matrix_addr #(.N(N), .IW(IW), .PW(PW)) u_scan_addr (
    .row(scan_row_q), .col(k_q),
    .pos(scan_pos), .is_diag(scan_diag), .out_of_range(scan_oor)
  );

  assign accept = bus.req_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    k_d         = k_q;
    scan_row_d  = scan_row_q;
    scan_vec_d  = scan_vec_q;
    clr_d       = clr_q;
    rsp_valid_d = 1'b0;
    rsp_bit_d   = rsp_bit_q;
    row_vec_d   = row_vec_q;
    scan_bit    = 1'b0;
`ifdef SYM_MATRIX_POPCOUNT_EN
    pop_d       = pop_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (bus.req_op)
            OP_READ: begin
              rsp_valid_d = 1'b1;
              rsp_bit_d   = req_oor ? 1'b0 : (req_diag ? DIAG : mem_q[req_pos]);
            end
            OP_WRITE: begin
              if (!req_oor && !req_diag) begin
                mem_d[req_pos] = bus.bit_in;
`ifdef SYM_MATRIX_POPCOUNT_EN
                if (mem_q[req_pos] != bus.bit_in)
                  pop_d = bus.bit_in ? pop_q + 1'b1 : pop_q - 1'b1;
`endif
              end
            end
            OP_ROW_READ: begin
              state_d    = ST_SCAN;
              scan_row_d = bus.row;
              k_d        = '0;
              scan_vec_d = '0;
            end
            default: begin
              state_d = ST_CLEAR;
              clr_d   = '0;
            end
          endcase
        end
      end
      ST_SCAN: begin
        scan_bit        = scan_oor ? 1'b0 : (scan_diag ? DIAG : mem_q[scan_pos]);
        scan_vec_d[k_q] = scan_bit;
        if (k_q == IW'(N - 1)) begin
          // Publish only on completion so row_vec stays stable mid-scan.
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          row_vec_d   = scan_vec_d;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_CLEAR: begin
        mem_d[clr_q] = 1'b0;
        if (clr_q == PW'(L - 1)) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
`ifdef SYM_MATRIX_POPCOUNT_EN
          pop_d       = '0;
`endif
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      mem_q       <= '0;
      k_q         <= '0;
      scan_row_q  <= '0;
      scan_vec_q  <= '0;
      clr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_bit_q   <= 1'b0;
      row_vec_q   <= '0;
`ifdef SYM_MATRIX_POPCOUNT_EN
      pop_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      k_q         <= k_d;
      scan_row_q  <= scan_row_d;
      scan_vec_q  <= scan_vec_d;
      clr_q       <= clr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_bit_q   <= rsp_bit_d;
      row_vec_q   <= row_vec_d;
`ifdef SYM_MATRIX_POPCOUNT_EN
      pop_q       <= pop_d;
`endif
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_bit   = rsp_bit_q;
  assign bus.row_vec   = row_vec_q;
  assign busy          = (state_q != ST_IDLE);
`ifdef SYM_MATRIX_POPCOUNT_EN
  assign pop_count     = pop_q;
`endif
endmodule

// File: tb/tb_sym_matrix_ctl.sv
// Directed bench for sym_matrix_ctl (N=8, L=28, DIAG=1); popcount steps are
// compiled in only with SYM_MATRIX_POPCOUNT_EN.
module tb_sym_matrix_ctl;
  import sym_matrix_pkg::*;

  logic clock;
  logic reset_n;
  logic busy;
`ifdef SYM_MATRIX_POPCOUNT_EN
  logic [4:0] pop_count;
`endif
  int n_cmp = 0;
  int n_bad = 0;

  sym_matrix_if #(.N(8)) bus_if ();

  sym_matrix_ctl dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if),
    .busy    (busy)
`ifdef SYM_MATRIX_POPCOUNT_EN
    ,
    .pop_count (pop_count)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach summary (obs=timeout exp=finish)");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents one request for one cycle and returns at
  // the following negedge (one cycle after acceptance).
  task automatic req(input logic [1:0] op, input int r, input int c, input logic b);
    bus_if.req_valid = 1'b1;
    bus_if.req_op    = op;
    bus_if.row       = 3'(r);
    bus_if.col       = 3'(c);
    bus_if.bit_in    = b;
    @(negedge clock);
    bus_if.req_valid = 1'b0;
    $display("txn op=%0d row=%0d col=%0d bit=%0b -> rsp_valid=%0b rsp_bit=%0b row_vec=%b busy=%0b",
             op, r, c, b, bus_if.rsp_valid, bus_if.rsp_bit, bus_if.row_vec, busy);
  endtask

  task automatic read_expect(input string tag, input int r, input int c, input logic exp);
    req(OP_READ, r, c, 1'b0);
    check({tag, ".valid"}, 32'(bus_if.rsp_valid), 32'd1);
    check({tag, ".bit"}, 32'(bus_if.rsp_bit), 32'(exp));
  endtask

  initial begin
    bus_if.req_valid = 1'b0;
    bus_if.req_op    = 2'b00;
    bus_if.row       = '0;
    bus_if.col       = '0;
    bus_if.bit_in    = 1'b0;
    reset_n          = 1'b0;
    repeat (2) @(negedge clock);

    check("rst.req_ready", 32'(bus_if.req_ready), 32'd1);
    check("rst.rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("rst.rsp_bit",   32'(bus_if.rsp_bit),   32'd0);
    check("rst.row_vec",   32'(bus_if.row_vec),   32'd0);
    check("rst.busy",      32'(busy),             32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Fresh array reads 0; diagonal reads DIAG.
    read_expect("rd35", 3, 5, 1'b0);
    read_expect("rd44", 4, 4, 1'b1);
    @(negedge clock);
    check("rsp_pulse", 32'(bus_if.rsp_valid), 32'd0);

    // Symmetric write then immediate read of the mirrored pair.
    req(OP_WRITE, 2, 6, 1'b1);
    check("wr26.no_rsp", 32'(bus_if.rsp_valid), 32'd0);
    check("wr26.rsp_bit_held", 32'(bus_if.rsp_bit), 32'd1);
    read_expect("rd62", 6, 2, 1'b1);
    read_expect("rd25", 2, 5, 1'b0);
    req(OP_WRITE, 5, 5, 1'b0);
    read_expect("rd55", 5, 5, 1'b1);

    // Row scan of row 3.
    req(OP_WRITE, 3, 0, 1'b1);
    req(OP_WRITE, 3, 7, 1'b1);
    req(OP_ROW_READ, 3, 0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("scan3.ready_c%0d", i), 32'(bus_if.req_ready), 32'd0);
      check($sformatf("scan3.rsp_c%0d", i), 32'(bus_if.rsp_valid), 32'd0);
      @(negedge clock);
    end
    check("scan3.rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
    check("scan3.row_vec", 32'(bus_if.row_vec), 32'h89);
    check("scan3.ready", 32'(bus_if.req_ready), 32'd1);
    read_expect("rd30", 3, 0, 1'b1);
    check("scan3.vec_held", 32'(bus_if.row_vec), 32'h89);

    // Row scan of row 2: M(2,6)=1 plus diagonal.
    req(OP_ROW_READ, 2, 0, 1'b0);
    repeat (8) @(negedge clock);
    check("scan2.rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
    check("scan2.row_vec", 32'(bus_if.row_vec), 32'h44);

    // Fill every location, then sweep-clear.
    for (int r = 1; r < 8; r++)
      for (int c = 0; c < r; c++)
        req(OP_WRITE, r, c, 1'b1);
    read_expect("fill.rd76", 7, 6, 1'b1);
    read_expect("fill.rd10", 0, 1, 1'b1);
`ifdef SYM_MATRIX_POPCOUNT_EN
    check("pop.full", 32'(pop_count), 32'd28);
`endif
    req(OP_CLEAR, 0, 0, 1'b0);
    for (int i = 1; i <= 28; i++) begin
      check($sformatf("clr.busy_c%0d", i), 32'(busy), 32'd1);
      check($sformatf("clr.rsp_c%0d", i), 32'(bus_if.rsp_valid), 32'd0);
      @(negedge clock);
    end
    check("clr.rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
    check("clr.busy_done", 32'(busy), 32'd0);
    check("clr.rsp_bit_held", 32'(bus_if.rsp_bit), 32'd1);
`ifdef SYM_MATRIX_POPCOUNT_EN
    check("pop.after_clr", 32'(pop_count), 32'd0);
`endif
    read_expect("clr.rd76", 7, 6, 1'b0);
    read_expect("clr.rd01", 0, 1, 1'b0);

`ifdef SYM_MATRIX_POPCOUNT_EN
    req(OP_WRITE, 1, 0, 1'b1);
    req(OP_WRITE, 4, 2, 1'b1);
    req(OP_WRITE, 6, 5, 1'b1);
    req(OP_WRITE, 1, 0, 1'b1);
    req(OP_WRITE, 4, 4, 1'b1);
    req(OP_WRITE, 2, 4, 1'b0);
    check("pop.two", 32'(pop_count), 32'd2);
    req(OP_CLEAR, 0, 0, 1'b0);
    repeat (10) @(negedge clock);
    check("pop.hold_mid_clr", 32'(pop_count), 32'd2);
    repeat (18) @(negedge clock);
    check("pop.clr_rsp", 32'(bus_if.rsp_valid), 32'd1);
    check("pop.zero", 32'(pop_count), 32'd0);
`endif

    // Reset in the middle of a row scan.
    req(OP_WRITE, 4, 1, 1'b1);
    read_expect("pre.rd41", 4, 1, 1'b1);
    req(OP_ROW_READ, 4, 0, 1'b0);
    repeat (3) @(negedge clock);
    check("abort.busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort.ready", 32'(bus_if.req_ready), 32'd1);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.row_vec", 32'(bus_if.row_vec), 32'd0);
    check("abort.rsp_bit", 32'(bus_if.rsp_bit), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check($sformatf("abort.no_rsp_c%0d", i), 32'(bus_if.rsp_valid), 32'd0);
    end
    read_expect("abort.rd41", 4, 1, 1'b0);
    read_expect("abort.rd76", 7, 6, 1'b0);
    read_expect("abort.rd44", 4, 4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sym_matrix_ctl.md
Name: sym_matrix_ctl

Overview:
- Parametrised successor of the team's symmetric-relation bit matrix.
- Stores the lower triangle (diagonal excluded) of an N x N symmetric, reflexive or irreflexive relation in a linear bit array, with a fixed diagonal value.
- Adds a valid/ready request port, registered responses, a multi-cycle row-scan read and a sequential clear sweep.
- Sits beside the equivalence/relation-tracking logic in the model suite as its relation store.

Parameters:
- N, 8: matrix dimension; any value >= 2, not restricted to a power of two.
- IW, $clog2(N): row/col index width.
- L, N*(N-1)/2: number of stored locations.
- PW, $clog2(L): linear position width.
- DIAG, 1'b1: value returned for row == col.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_op  in  2  00 READ, 01 WRITE, 10 ROW_READ, 11 CLEAR.
- row  in  IW  row index.
- col  in  IW  column index; ignored for ROW_READ and CLEAR.
- bit_in  in  1  write data.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_bit  out  1  READ result.
- row_vec  out  N  ROW_READ result; bit k = M(row,k).
- busy  out  1  FSM not in IDLE.

Behaviour:
- Storage position for r != c: with hi = max(r,c) and lo = min(r,c), pos = hi*(hi-1)/2 + lo, computed combinationally. No offset table.
- Reset (reset_n = 0, asynchronous):
  - All L bits cleared; FSM to IDLE.
  - req_ready = 1, rsp_valid = 0, rsp_bit = 0, row_vec = 0, busy = 0.
- A request is accepted when req_valid & req_ready at the clock edge. At most one request per cycle.
- FSM states: IDLE, SCAN, CLEAR. req_ready = (state == IDLE).
- READ (stays in IDLE):
  - rsp_valid pulses the cycle after acceptance (latency 1).
  - rsp_bit = DIAG if row == col, else M[pos].
- WRITE (stays in IDLE):
  - M[pos] <= bit_in at acceptance; no response.
  - row == col: no-op.
  - A READ accepted the next cycle returns the new value.
- ROW_READ:
  - IDLE -> SCAN; column counter k runs 0..N-1, one stored bit per cycle (single-port array model).
  - row_vec[k] is filled each cycle; row_vec[row] = DIAG.
  - After k = N-1: -> IDLE, and rsp_valid pulses that same edge. Total latency N+1 cycles from acceptance.
  - row_vec holds its value until the next ROW_READ completes.
- CLEAR:
  - IDLE -> CLEAR; a position counter clears one location per cycle, 0..L-1.
  - At L-1: -> IDLE, with a rsp_valid pulse. Latency L+1.
- Out-of-range index (row or col >= N, only possible when N is not a power of two):
  - WRITE is a no-op.
  - READ returns 0.
  - ROW_READ returns all zeros.
  - The response is still generated.
- rsp_bit changes only on READ responses.
- A reset asserted mid-SCAN or mid-CLEAR aborts immediately. No rsp_valid; partial row_vec discarded (zeroed); array fully cleared by the reset.
- Counters wrap only by FSM termination; they are never compared past N-1 or L-1.

Optional Feature:
- Macro: SYM_MATRIX_POPCOUNT_EN.
- When defined, adds output pop_count, width $clog2(L+1): the number of stored bits equal to 1.
  - Incremented on a WRITE changing 0->1; decremented on 1->0; unchanged on a same-value or diagonal write.
  - Zeroed on reset.
  - Zeroed the cycle CLEAR completes; holds its pre-CLEAR value during the sweep.
- When not defined, the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package sym_matrix_pkg holds:
  - op encodings (OP_READ, OP_WRITE, OP_ROW_READ, OP_CLEAR);
  - state enum (ST_IDLE, ST_SCAN, ST_CLEAR);
  - function tri_pos(hi, lo) returning hi*(hi-1)/2 + lo.
- One combinational sub-module, sym_matrix_addr: takes row/col, outputs pos, is_diag and out_of_range. It is instantiated twice: once for the request port and once for the scan (row, k).

Test Plan (N = 8, L = 28, DIAG = 1):
- Reset, then READ (3,5) -> rsp_valid one cycle later, rsp_bit = 0; READ (4,4) -> rsp_bit = 1.
- WRITE (2,6) = 1, then READ (6,2) next cycle -> rsp_bit = 1 (symmetry, pos = 17). WRITE (5,5) = 0 -> READ (5,5) still returns 1.
- WRITE (3,0) = 1 and (3,7) = 1, then ROW_READ row 3 -> req_ready low 8 cycles, rsp_valid at cycle 9, row_vec = 8'b1000_1001.
- Fill all 28 locations with 1, then CLEAR -> busy for 28 cycles, rsp_valid at cycle 29; subsequent READ of (7,6) returns 0.
- Start ROW_READ, deassert reset_n at scan cycle 4 -> no rsp_valid, row_vec = 0, req_ready = 1 immediately, all reads return 0.
- With SYM_MATRIX_POPCOUNT_EN: write 1 to 3 distinct pairs, rewrite one with 1, write one to 0 -> pop_count = 2; CLEAR -> pop_count = 0 at completion.
